// File: rtl/div_share_arbiter.sv
// -----------------------------------------------------------------------------
// div_share_arbiter
//
// Round-robin arbiter and sequencer that shares one multi-cycle 8-bit unsigned
// divider among NREQ requesters. One request is in flight at a time. A zero
// divisor is answered directly with an error and the divider is not used. A
// divider that never reports completion is abandoned after TIMEOUT cycles.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   req_valid_i  per-requester request pending (held until granted)
//   req_a_i      dividends, requester i at [8i+7:8i]
//   req_b_i      divisors, same packing
//   req_ready_o  one-hot grant, combinational, nonzero only while idle
//   rsp_valid_o  one-hot single-cycle response pulse to the owner (registered)
//   rsp_data_o   quotient, or 8'hFF on error
//   rsp_err_o    1 = divide-by-zero or divider timeout
//   busy_o       registered, 1 whenever a request is being handled
//   div_start_o  single-cycle start pulse to the divider
//   div_a_o      dividend to the divider, held from start until done
//   div_b_o      divisor to the divider, held from start until done
//   div_res_i    divider quotient, sampled when div_done_i is high
//   div_done_i   divider completion pulse (only observed while waiting)
// -----------------------------------------------------------------------------
module div_share_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid_i,
    input  logic [8*NREQ-1:0] req_a_i,
    input  logic [8*NREQ-1:0] req_b_i,
    output logic [NREQ-1:0]   req_ready_o,
    output logic [NREQ-1:0]   rsp_valid_o,
    output logic [7:0]        rsp_data_o,
    output logic              rsp_err_o,
    output logic              busy_o,
    output logic              div_start_o,
    output logic [7:0]        div_a_o,
    output logic [7:0]        div_b_o,
    input  logic [7:0]        div_res_i,
    input  logic              div_done_i
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [NREQ-1:0]  ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NREQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  rr_q, rr_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [7:0]        rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;
    logic              busy_q, busy_d;
    logic              div_start_q, div_start_d;
    logic [7:0]        div_a_q, div_a_d;
    logic [7:0]        div_b_q, div_b_d;

    logic [7:0]        a_arr_s [NREQ];
    logic [7:0]        b_arr_s [NREQ];
    logic              win_found_s;
    logic [IDX_W-1:0]  win_idx_s;
    logic [IDX_W:0]    sum_s;
    logic [IDX_W-1:0]  cand_s;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign a_arr_s[g] = req_a_i[8*g +: 8];
        assign b_arr_s[g] = req_b_i[8*g +: 8];
    end

    // Round-robin winner search: first pending requester at or after rr_q, wrapping.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        sum_s       = '0;
        cand_s      = '0;
        for (int k = 0; k < NREQ; k++) begin
            // rr_q + k never reaches 2*NREQ, so one conditional subtract is a full modulo.
            sum_s = {1'b0, rr_q} + (IDX_W+1)'(k);
            if (sum_s >= (IDX_W+1)'(NREQ)) begin
                sum_s = sum_s - (IDX_W+1)'(NREQ);
            end else begin
                sum_s = sum_s;
            end
            cand_s = sum_s[IDX_W-1:0];
            if (!win_found_s && req_valid_i[cand_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Grant is combinational and only offered while idle.
    always_comb begin
        if ((state_q == ST_IDLE) && win_found_s) begin
            req_ready_o = ONE_HOT0 << win_idx_s;
        end else begin
            req_ready_o = '0;
        end
    end

    // Next-state and next-output logic of the sequencer.
    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        div_a_d    = div_a_q;
        div_b_d    = div_b_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found_s) begin
                    owner_d = win_idx_s;
                    div_a_d = a_arr_s[win_idx_s];
                    div_b_d = b_arr_s[win_idx_s];
                    if (b_arr_s[win_idx_s] == 8'h00) begin
                        // Zero divisor never reaches the divider.
                        rsp_data_d = 8'hFF;
                        rsp_err_d  = 1'b1;
                        state_d    = ST_RESP;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Completion is checked before the limit so a simultaneous done wins.
                if (div_done_i) begin
                    rsp_data_d = div_res_i;
                    rsp_err_d  = 1'b0;
                    state_d    = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_data_d = 8'hFF;
                    rsp_err_d  = 1'b1;
                    state_d    = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (owner_q == IDX_LAST) begin
                    rr_d = '0;
                end else begin
                    rr_d = owner_q + IDX_W'(1);
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Registered outputs are derived from the state being entered so they
        // line up exactly with that state's cycle.
        rsp_valid_d = (state_d == ST_RESP) ? (ONE_HOT0 << owner_d) : '0;
        busy_d      = (state_d != ST_IDLE);
        div_start_d = (state_d == ST_ISSUE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_q        <= '0;
            owner_q     <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= 8'h00;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            div_start_q <= 1'b0;
            div_a_q     <= 8'h00;
            div_b_q     <= 8'h00;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
            div_start_q <= div_start_d;
            div_a_q     <= div_a_d;
            div_b_q     <= div_b_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;
    assign busy_o      = busy_q;
    assign div_start_o = div_start_q;
    assign div_a_o     = div_a_q;
    assign div_b_o     = div_b_q;

endmodule

// File: tb/tb_div_share_arbiter.sv
module tb_div_share_arbiter;

    localparam int NREQ = 4;
    localparam int TMO  = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_a;
    logic [8*NREQ-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic [7:0]        rsp_data;
    logic              rsp_err;
    logic              busy;
    logic              div_start;
    logic [7:0]        div_a;
    logic [7:0]        div_b;
    logic [7:0]        div_res;
    logic              div_done;

    div_share_arbiter #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .req_ready_o (req_ready),
        .rsp_valid_o (rsp_valid),
        .rsp_data_o  (rsp_data),
        .rsp_err_o   (rsp_err),
        .busy_o      (busy),
        .div_start_o (div_start),
        .div_a_o     (div_a),
        .div_b_o     (div_b),
        .div_res_i   (div_res),
        .div_done_i  (div_done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Transaction-level reference model (absolute cycle numbers).
    int         m_free, m_rr, m_owner, m_rsp_cyc, m_start_cyc;
    logic [7:0] m_a, m_b, m_data;
    logic       m_err;
    // Divider environment: latency for the next accepted op (-1 = never done).
    int         txn_L, cur_L, done_cyc;
    logic       stray;
    logic [7:0] stray_res;
    // Last observed outputs.
    logic [NREQ-1:0] obs_ready, obs_rsp;
    logic [7:0]      obs_data;
    logic            obs_err, obs_start, obs_busy;

    typedef struct {
        int              idx;
        logic [7:0]      a;
        logic [7:0]      b;
        int              lat_L;
        logic [NREQ-1:0] exp_onehot;
        logic [7:0]      exp_data;
        logic            exp_err;
        int              exp_lat;
        int              exp_starts;
    } vec_t;

    vec_t tbl [8];
    int   rr_exp_idx  [5];
    int   rr_exp_data [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [NREQ-1:0] onehot(input int i);
        logic [NREQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic int winner();
        int i;
        for (int k = 0; k < NREQ; k++) begin
            i = (m_rr + k) % NREQ;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_free      = cyc;
        m_rr        = 0;
        m_owner     = 0;
        m_rsp_cyc   = -1;
        m_start_cyc = -1;
        done_cyc    = -1;
        cur_L       = -1;
    endtask

    task automatic model_accept(input int w);
        m_owner = w;
        m_a     = req_a[8*w +: 8];
        m_b     = req_b[8*w +: 8];
        m_rr    = (w + 1) % NREQ;
        cur_L   = txn_L;
        if (m_b == 8'h00) begin
            m_start_cyc = -1;
            m_rsp_cyc   = cyc + 1;
            m_data      = 8'hFF;
            m_err       = 1'b1;
        end else begin
            m_start_cyc = cyc + 1;
            if (txn_L >= 0 && txn_L <= TMO - 1) begin
                m_rsp_cyc = cyc + txn_L + 3;
                m_data    = m_a / m_b;
                m_err     = 1'b0;
            end else begin
                m_rsp_cyc = cyc + TMO + 2;
                m_data    = 8'hFF;
                m_err     = 1'b1;
            end
        end
        m_free = m_rsp_cyc + 1;
    endtask

    // One clock cycle: called at negedge with inputs set; checks, then advances.
    task automatic step();
        int              w;
        bit              idle;
        logic [NREQ-1:0] exp_ready, exp_rsp;
        if (done_cyc == cyc) begin
            div_done = 1'b1;
            div_res  = (div_b != 8'h00) ? div_a / div_b : 8'hFF;
        end else if (stray) begin
            div_done = 1'b1;
            div_res  = stray_res;
        end else begin
            div_done = 1'b0;
            div_res  = 8'h00;
        end
        #1;
        idle      = (cyc >= m_free);
        w         = winner();
        exp_ready = (idle && w >= 0) ? onehot(w) : '0;
        exp_rsp   = (cyc == m_rsp_cyc) ? onehot(m_owner) : '0;
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        chk("busy", 32'(busy), 32'(!idle));
        chk("div_start", 32'(div_start), 32'(cyc == m_start_cyc));
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
        if (cyc == m_rsp_cyc) begin
            chk("rsp_data", 32'(rsp_data), 32'(m_data));
            chk("rsp_err", 32'(rsp_err), 32'(m_err));
        end
        if (!idle) begin
            chk("div_a", 32'(div_a), 32'(m_a));
            chk("div_b", 32'(div_b), 32'(m_b));
        end
        obs_ready = req_ready;
        obs_rsp   = rsp_valid;
        obs_data  = rsp_data;
        obs_err   = rsp_err;
        obs_start = div_start;
        obs_busy  = busy;
        @(posedge clk);
        if (obs_start) done_cyc = (cur_L < 0) ? -1 : cyc + cur_L + 1;
        if (idle && w >= 0) model_accept(w);
        cyc++;
        @(negedge clk);
        stray = 1'b0;
    endtask

    task automatic reset_now();
        rst       = 1'b1;
        req_valid = '0;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_div_a", 32'(div_a), 32'd0);
        chk("rst_div_b", 32'(div_b), 32'd0);
        chk("rst_div_start", 32'(div_start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int got, nrsp, ngr, a_cyc, r_cyc, starts;
        logic [NREQ-1:0] g_v, r_v;
        logic [7:0]      r_d;
        logic            r_e;
        int              gr_idx [8];
        int              rs_dat [8];

        tbl[0] = '{0, 8'd100, 8'd7,   9,       4'b0001, 8'd14,  1'b0, 12,      1};
        tbl[1] = '{2, 8'd55,  8'd0,   5,       4'b0100, 8'hFF,  1'b1, 1,       0};
        tbl[2] = '{1, 8'd77,  8'd3,   -1,      4'b0010, 8'hFF,  1'b1, TMO + 2, 1};
        tbl[3] = '{3, 8'd90,  8'd9,   2,       4'b1000, 8'd10,  1'b0, 5,       1};
        tbl[4] = '{1, 8'd250, 8'd6,   TMO - 1, 4'b0010, 8'd41,  1'b0, TMO + 2, 1};
        tbl[5] = '{3, 8'd255, 8'd1,   1,       4'b1000, 8'd255, 1'b0, 4,       1};
        tbl[6] = '{0, 8'd0,   8'd200, 3,       4'b0001, 8'd0,   1'b0, 6,       1};
        tbl[7] = '{1, 8'd9,   8'd0,   4,       4'b0010, 8'hFF,  1'b1, 1,       0};
        rr_exp_idx  = '{0, 1, 2, 3, 0};
        rr_exp_data = '{200, 100, 66, 50, 200};

        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
        div_res = 8'h00; div_done = 1'b0; stray = 1'b0; stray_res = 8'h00; txn_L = 1;
        m_a = 8'h00; m_b = 8'h00; m_data = 8'h00; m_err = 1'b0;
        @(negedge clk);
        reset_now();
        step();

        // Stray div_done while idle must have no effect.
        for (int n = 0; n < 3; n++) begin
            stray = 1'b1; stray_res = 8'h5A;
            step();
        end

        // Table of single requests.
        for (int r = 0; r < 8; r++) begin
            req_a = '0; req_b = '0;
            req_a[8*tbl[r].idx +: 8] = tbl[r].a;
            req_b[8*tbl[r].idx +: 8] = tbl[r].b;
            req_valid = onehot(tbl[r].idx);
            txn_L = tbl[r].lat_L;
            got = 0; nrsp = 0; starts = 0; a_cyc = 0; r_cyc = 0;
            g_v = '0; r_v = '0; r_d = 8'h00; r_e = 1'b0;
            for (int n = 0; n < 64 && nrsp == 0; n++) begin
                step();
                if (obs_start) starts++;
                if (got == 0 && obs_ready != '0) begin
                    got = 1; g_v = obs_ready; a_cyc = cyc - 1; req_valid = '0;
                end
                if (obs_rsp != '0) begin
                    nrsp = 1; r_v = obs_rsp; r_d = obs_data; r_e = obs_err; r_cyc = cyc - 1;
                end
            end
            chk($sformatf("row%0d_responded", r), 32'(nrsp), 32'd1);
            chk($sformatf("row%0d_grant", r), 32'(g_v), 32'(tbl[r].exp_onehot));
            chk($sformatf("row%0d_rsp_valid", r), 32'(r_v), 32'(tbl[r].exp_onehot));
            chk($sformatf("row%0d_data", r), 32'(r_d), 32'(tbl[r].exp_data));
            chk($sformatf("row%0d_err", r), 32'(r_e), 32'(tbl[r].exp_err));
            chk($sformatf("row%0d_latency", r), 32'(r_cyc - a_cyc), 32'(tbl[r].exp_lat));
            chk($sformatf("row%0d_starts", r), 32'(starts), 32'(tbl[r].exp_starts));
            step();
        end

        // Reset three cycles into WAIT, with the round-robin pointer away from 0.
        req_a = '0; req_b = '0;
        req_a[8*3 +: 8] = 8'd60; req_b[8*3 +: 8] = 8'd5;
        req_valid = onehot(3); txn_L = -1; got = 0;
        for (int n = 0; n < 16 && got == 0; n++) begin
            step();
            if (obs_ready != '0) begin got = 1; req_valid = '0; end
        end
        chk("rstwait_granted", 32'(got), 32'd1);
        for (int n = 0; n < 3; n++) step();
        chk("rstwait_busy_before", 32'(obs_busy), 32'd1);
        reset_now();
        for (int n = 0; n < 4; n++) step();

        // Round-robin: all requesters pending continuously.
        for (int i = 0; i < NREQ; i++) begin
            req_a[8*i +: 8] = 8'd200;
            req_b[8*i +: 8] = 8'(i + 1);
        end
        req_valid = '1; txn_L = 2; ngr = 0; nrsp = 0;
        for (int n = 0; n < 200 && nrsp < 5; n++) begin
            step();
            if (obs_ready != '0 && ngr < 8) begin
                for (int i = 0; i < NREQ; i++) if (obs_ready[i]) gr_idx[ngr] = i;
                if (ngr == 0) chk("grant_after_reset", 32'(obs_ready), 32'h1);
                ngr++;
            end
            if (obs_rsp != '0) begin
                rs_dat[nrsp] = int'(obs_data);
                nrsp++;
            end
        end
        chk("rr_responses", 32'(nrsp), 32'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < nrsp) begin
                chk($sformatf("rr_grant%0d", k), 32'(gr_idx[k]), 32'(rr_exp_idx[k]));
                chk($sformatf("rr_data%0d", k), 32'(rs_dat[k]), 32'(rr_exp_data[k]));
            end
        end
        req_valid = '0;
        for (int n = 0; n < 12; n++) step();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                req_a[8*i +: 8] = 8'($urandom);
                req_b[8*i +: 8] = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            end
            req_valid = NREQ'($urandom);
            txn_L     = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(1, TMO + 2));
            stray     = (cyc >= m_free) && ($urandom_range(0, 7) == 0);
            stray_res = 8'($urandom);
            step();
        end
        req_valid = '0;
        for (int n = 0; n < TMO + 8; n++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
